// File: rtl/bcedn_head_pkg.sv
// Shared types, config selectors and derived-width helpers for the binary decoder head.
package bcedn_head_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_ARG, ST_EMIT} state_t;
  typedef enum logic {MODE_RAW = 1'b0, MODE_ARGMAX = 1'b1} mode_t;

  localparam logic [1:0] CFG_WEIGHT = 2'd0;
  localparam logic [1:0] CFG_REF    = 2'd1;
  localparam logic [1:0] CFG_SCALE  = 2'd2;
  localparam logic [1:0] CFG_RSVD   = 2'd3;

  function automatic int f_cw(input int d);
    return $clog2(d + 1);
  endfunction

  function automatic int f_conv_out_w(input int cw, input int nr);
    return (((cw + 1) > nr) ? (cw + 1) : nr) + 1;
  endfunction

  function automatic int f_pe_out_w(input int cow, input int ns);
    return cow + ns;
  endfunction

endpackage

// File: rtl/bcedn_xnor_pe.sv
// One combinational lane: XNOR-popcount against a weight row, then ref offset and scale.
module bcedn_xnor_pe
  import bcedn_head_pkg::*;
#(
  parameter int D                   = 512,
  parameter int NORMREF_WIDTH       = 15,
  parameter int NORMREF_SCALE_WIDTH = 15,
  localparam int CW  = f_cw(D),
  localparam int COW = f_conv_out_w(CW, NORMREF_WIDTH),
  localparam int PW  = f_pe_out_w(COW, NORMREF_SCALE_WIDTH)
) (
  input  logic [D-1:0]                          i_x,
  input  logic [D-1:0]                          i_w,
  input  logic signed [NORMREF_WIDTH-1:0]       i_ref,
  input  logic signed [NORMREF_SCALE_WIDTH-1:0] i_scale,
  output logic signed [PW-1:0]                  o_score
);

  logic [CW-1:0]         w_pop;
  logic signed [CW:0]    w_conv;
  logic signed [COW-1:0] w_t;

  assign w_pop  = CW'($countones(~(i_x ^ i_w)));
  // 2*pop fits CW+1 bits modulo 2^(CW+1); the difference always lands in range.
  assign w_conv = signed'({w_pop, 1'b0} - (CW + 1)'(D));
  assign w_t    = COW'(w_conv) - COW'(i_ref);
  assign o_score = PW'(w_t) * PW'(i_scale);

endmodule

// File: rtl/bcedn_decoder_head.sv
// Decoder output head: streams per-channel binary-conv scores (RAW) or the argmax class per pixel.
module bcedn_decoder_head
  import bcedn_head_pkg::*;
#(
  parameter int D                   = 512,
  parameter int FD                  = 16,
  parameter int N_PE                = 4,
  parameter int NORMREF_WIDTH       = 15,
  parameter int NORMREF_SCALE_WIDTH = 15,
  parameter int NPIX                = 2048,
  localparam int CW    = f_cw(D),
  localparam int COW   = f_conv_out_w(CW, NORMREF_WIDTH),
  localparam int PW    = f_pe_out_w(COW, NORMREF_SCALE_WIDTH),
  localparam int CLS_W = (FD > 1) ? $clog2(FD) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_mode,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [D-1:0]         i_data_in,
  input  logic                 i_cfg_we,
  input  logic [1:0]           i_cfg_sel,
  input  logic [CLS_W-1:0]     i_cfg_addr,
  input  logic [D-1:0]         i_cfg_wdata,
  output logic                 o_cfg_drop,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [N_PE*PW-1:0]   o_out_data,
  output logic [CLS_W-1:0]     o_out_class,
  output logic                 o_out_last,
  output logic                 o_done
);

  localparam int G   = FD / N_PE;
  localparam int GW  = (G > 1) ? $clog2(G) : 1;
  localparam int PCW = (NPIX > 1) ? $clog2(NPIX) : 1;

  state_t                          r_state;
  logic [D-1:0]                    r_x;
  logic [GW-1:0]                   r_g;
  logic [PCW-1:0]                  r_pix;
  logic signed [PW-1:0]            r_best;
  logic [CLS_W-1:0]                r_best_idx;
  logic                            r_out_valid, r_out_last, r_done, r_cfg_drop;
  logic [N_PE*PW-1:0]              r_out_data;
  logic [CLS_W-1:0]                r_out_class;
  logic [D-1:0]                    r_w     [FD];
  logic signed [NORMREF_WIDTH-1:0] r_ref   [FD];
  logic signed [NORMREF_SCALE_WIDTH-1:0] r_scale [FD];

  logic signed [PW-1:0] w_score [N_PE];
  logic [CLS_W-1:0]     w_ch    [N_PE];
  logic [N_PE*PW-1:0]   w_raw_beat, w_arg_beat;
  logic signed [PW-1:0] w_gbest, w_best_fin;
  logic [CLS_W-1:0]     w_gbest_idx, w_best_fin_idx;
  logic                 w_accept, w_g_last, w_cfg_idle, w_cfg_wr, w_cfg_drop;

  assign o_in_ready  = (r_state == ST_IDLE) && !i_rst;
  assign w_accept    = i_in_valid && o_in_ready;
  assign w_g_last    = (r_g == GW'(G - 1));
  assign w_cfg_idle  = (r_state == ST_IDLE) && !w_accept;
  assign w_cfg_wr    = i_cfg_we && (i_cfg_sel != CFG_RSVD) && w_cfg_idle;
  assign w_cfg_drop  = i_cfg_we && (i_cfg_sel != CFG_RSVD) && !w_cfg_idle;

  for (genvar l = 0; l < N_PE; l++) begin : g_lane
    assign w_ch[l] = CLS_W'(int'(r_g) * N_PE + l);
    bcedn_xnor_pe #(
      .D                  (D),
      .NORMREF_WIDTH      (NORMREF_WIDTH),
      .NORMREF_SCALE_WIDTH(NORMREF_SCALE_WIDTH)
    ) u_pe (
      .i_x    (r_x),
      .i_w    (r_w[w_ch[l]]),
      .i_ref  (r_ref[w_ch[l]]),
      .i_scale(r_scale[w_ch[l]]),
      .o_score(w_score[l])
    );
  end

  // Lane packing and argmax reduction; strict '>' keeps the lowest channel on ties.
  always_comb begin
    w_raw_beat  = '0;
    w_arg_beat  = '0;
    w_gbest     = w_score[0];
    w_gbest_idx = w_ch[0];
    for (int l = 0; l < N_PE; l++) begin
      w_raw_beat[(N_PE-1-l)*PW +: PW] = w_score[l];
      w_gbest_idx = (w_score[l] > w_gbest) ? w_ch[l] : w_gbest_idx;
      w_gbest     = (w_score[l] > w_gbest) ? w_score[l] : w_gbest;
    end
    w_best_fin     = ((r_g == '0) || (w_gbest > r_best)) ? w_gbest : r_best;
    w_best_fin_idx = ((r_g == '0) || (w_gbest > r_best)) ? w_gbest_idx : r_best_idx;
    w_arg_beat[(N_PE-1)*PW +: PW] = w_best_fin;
  end

  // Weight/ref/scale store; deliberately left without reset.
  always_ff @(posedge i_clk) begin
    if (w_cfg_wr) begin
      case (i_cfg_sel)
        CFG_WEIGHT: r_w[i_cfg_addr]     <= i_cfg_wdata;
        CFG_REF:    r_ref[i_cfg_addr]   <= NORMREF_WIDTH'(signed'(i_cfg_wdata));
        CFG_SCALE:  r_scale[i_cfg_addr] <= NORMREF_SCALE_WIDTH'(signed'(i_cfg_wdata));
        default:    ;
      endcase
    end
  end

  // Control FSM with output register, pixel counter and status pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_x         <= '0;
      r_g         <= '0;
      r_pix       <= '0;
      r_best      <= '0;
      r_best_idx  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_out_class <= '0;
      r_done      <= 1'b0;
      r_cfg_drop  <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_cfg_drop <= w_cfg_drop;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_x     <= i_data_in;
            r_g     <= '0;
            r_state <= (i_mode == MODE_ARGMAX) ? ST_ARG : ST_RUN;
          end
        end
        ST_RUN: begin
          if (!r_out_valid || i_out_ready) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_raw_beat;
            r_out_class <= '0;
            r_out_last  <= w_g_last;
            r_g         <= r_g + GW'(1);
            if (w_g_last) begin
              r_state <= ST_EMIT;
            end
          end
        end
        ST_ARG: begin
          r_best     <= w_best_fin;
          r_best_idx <= w_best_fin_idx;
          r_g        <= r_g + GW'(1);
          if (w_g_last) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_arg_beat;
            r_out_class <= w_best_fin_idx;
            r_out_last  <= 1'b1;
            r_state     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= (r_pix == PCW'(NPIX - 1));
            r_pix       <= (r_pix == PCW'(NPIX - 1)) ? '0 : r_pix + PCW'(1);
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (i_start) begin
        r_pix <= '0;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_class = r_out_class;
  assign o_out_last  = r_out_last;
  assign o_done      = r_done;
  assign o_cfg_drop  = r_cfg_drop;

endmodule

// File: tb/tb_bcedn_decoder_head.sv
// Directed bench for bcedn_decoder_head with D=8, FD=4, N_PE=2, NPIX=2.
module tb_bcedn_decoder_head;

  localparam int D = 8, FD = 4, N_PE = 2, NPIX = 2, PW = 31, CLS_W = 2;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0;
  logic in_valid = 1'b0, in_ready, cfg_we = 1'b0, cfg_drop;
  logic [D-1:0] data_in = '0, cfg_wdata = '0;
  logic [1:0] cfg_sel = 2'd0;
  logic [CLS_W-1:0] cfg_addr = '0, out_class;
  logic out_valid, out_ready = 1'b1, out_last, done;
  logic [N_PE*PW-1:0] out_data;

  int n_total = 0, n_bad = 0, hs_cnt = 0, done_cnt = 0;
  int hs0, dn0;

  bcedn_decoder_head #(.D(D), .FD(FD), .N_PE(N_PE), .NPIX(NPIX)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_data_in(data_in),
    .i_cfg_we(cfg_we), .i_cfg_sel(cfg_sel), .i_cfg_addr(cfg_addr),
    .i_cfg_wdata(cfg_wdata), .o_cfg_drop(cfg_drop), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_out_data(out_data), .o_out_class(out_class),
    .o_out_last(out_last), .o_done(done)
  );

  always #5 clk = ~clk;

  // Handshakes and done pulses observed mid-cycle.
  always @(negedge clk) begin
    if (out_valid && out_ready) hs_cnt++;
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [63:0] lane(input int l);
    logic signed [PW-1:0] v;
    v = out_data[(N_PE-1-l)*PW +: PW];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [1:0] addr, input logic [7:0] dat);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = dat;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic accept(input logic [7:0] px, input logic m);
    int n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    chk("accept_ready", in_ready, 1);
    in_valid = 1'b1; data_in = px; mode = m;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    chk(tag, out_valid, 1);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (!(in_ready && !out_valid) && n < 20) begin step(); n++; end
    chk("drain_idle", in_ready && !out_valid, 1);
  endtask

  initial begin
    #1;
    chk("rst_in_ready", in_ready, 0);
    repeat (2) step();
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);
    chk("rel_out_data", out_data, 0);
    chk("rel_out_class", out_class, 0);
    chk("rel_out_last", out_last, 0);
    chk("rel_done", done, 0);
    chk("rel_cfg_drop", cfg_drop, 0);

    cfg_write(2'd0, 2'd0, 8'hFF);
    cfg_write(2'd0, 2'd1, 8'h00);
    cfg_write(2'd0, 2'd2, 8'h0F);
    cfg_write(2'd0, 2'd3, 8'hF0);
    for (int c = 0; c < FD; c++) begin
      cfg_write(2'd1, 2'(c), 8'h00);
      cfg_write(2'd2, 2'(c), 8'h01);
    end

    // RAW 0xFF, latency and contents
    out_ready = 1'b1;
    accept(8'hFF, 1'b0);
    chk("raw_lat_c1", out_valid, 0);
    step();
    chk("raw_lat_c2", out_valid, 1);
    chk("raw_b0_l0", lane(0), 8);
    chk("raw_b0_l1", lane(1), -8);
    chk("raw_b0_last", out_last, 0);
    step();
    chk("raw_b1_valid", out_valid, 1);
    chk("raw_b1_l0", lane(0), 0);
    chk("raw_b1_l1", lane(1), 0);
    chk("raw_b1_last", out_last, 1);
    chk("raw_b1_class", out_class, 0);
    step();
    chk("raw_end_valid", out_valid, 0);
    chk("raw_end_ready", in_ready, 1);

    // RAW backpressure on beat0
    pulse_start();
    out_ready = 1'b0;
    hs0 = hs_cnt;
    accept(8'hFF, 1'b0);
    wait_valid("bp_valid");
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_l0", lane(0), 8);
      chk("bp_hold_l1", lane(1), -8);
      chk("bp_hold_last", out_last, 0);
      if (k < 2) step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_b1_l0", lane(0), 0);
    chk("bp_b1_last", out_last, 1);
    drain();
    chk("bp_beats", hs_cnt - hs0, 2);

    // ARGMAX 0x0F
    accept(8'h0F, 1'b1);
    wait_valid("arg_valid");
    chk("arg_class", out_class, 2);
    chk("arg_l0", lane(0), 8);
    chk("arg_l1", lane(1), 0);
    chk("arg_last", out_last, 1);
    drain();

    // ARGMAX tie between ch1 and ch3
    cfg_write(2'd0, 2'd3, 8'h00);
    accept(8'h00, 1'b1);
    wait_valid("tie_valid");
    chk("tie_class", out_class, 1);
    chk("tie_l0", lane(0), 8);
    drain();

    // ref=2, scale=-3 on ch0
    cfg_write(2'd1, 2'd0, 8'h02);
    cfg_write(2'd2, 2'd0, 8'hFD);
    accept(8'hFF, 1'b0);
    wait_valid("rs_valid");
    chk("rs_b0_l0", lane(0), -18);
    chk("rs_b0_l1", lane(1), -8);
    step();
    chk("rs_b1_l0", lane(0), 0);
    chk("rs_b1_l1", lane(1), -8);
    chk("rs_b1_last", out_last, 1);
    drain();

    // done over two back-to-back pixels, then start clears the count
    pulse_start();
    dn0 = done_cnt;
    accept(8'hFF, 1'b0);
    wait_valid("dn_a_valid");
    drain();
    chk("dn_after_a", done_cnt - dn0, 0);
    accept(8'hFF, 1'b0);
    wait_valid("dn_b_valid");
    step();
    chk("dn_b_last", out_last, 1);
    step();
    chk("dn_pulse", done, 1);
    step();
    chk("dn_pulse_end", done, 0);
    chk("dn_count", done_cnt - dn0, 1);
    accept(8'hFF, 1'b0);
    wait_valid("dn_c_valid");
    drain();
    pulse_start();
    accept(8'hFF, 1'b0);
    wait_valid("dn_d_valid");
    drain();
    chk("dn_start_clr", done_cnt - dn0, 1);

    // config write during RUN is dropped; reserved select never drops
    out_ready = 1'b0;
    accept(8'hFF, 1'b0);
    cfg_write(2'd0, 2'd2, 8'hFF);
    chk("drop_pulse", cfg_drop, 1);
    cfg_write(2'd3, 2'd2, 8'hFF);
    chk("drop_clear", cfg_drop, 0);
    step();
    chk("rsvd_nodrop", cfg_drop, 0);
    drain();
    accept(8'hFF, 1'b0);
    wait_valid("drop_chk_valid");
    step();
    chk("drop_w_kept", lane(0), 0);
    drain();

    // reset while holding the final beat
    out_ready = 1'b0;
    accept(8'hFF, 1'b0);
    wait_valid("mr_valid");
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    chk("mr_emit_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mr_rst_valid", out_valid, 0);
    chk("mr_rst_ready", in_ready, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_rel_valid", out_valid, 0);
    chk("mr_rel_ready", in_ready, 1);
    chk("mr_rel_last", out_last, 0);
    step();
    chk("mr_idle_ready", in_ready, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/bcedn_decoder_head.md
Name: bcedn_decoder_head

Overview:
- Parametrised successor of the binary decoder output stage.
- Applies a 1x1 binary (XNOR-popcount) convolution to each D-bit pixel and produces FD per-channel scores, each with normalisation reference and scale applied.
- Adds a valid/ready stream with backpressure, a runtime RAW/ARGMAX mode, a run-time loadable weight/ref/scale store, and frame-level pixel counting with done.
- Sits at the end of the decoder chain and feeds the classification writer.

Parameters:
- D, 512: input pixel bit width (binary channels).
- FD, 16: output channels (classes); FD % N_PE == 0.
- N_PE, 4: parallel PE lanes; G = FD/N_PE groups per pixel.
- NORMREF_WIDTH, 15: signed ref width.
- NORMREF_SCALE_WIDTH, 15: signed scale width.
- NPIX, 2048: pixels per frame.
- Derived: CW = clog2(D+1); CONV_OUT_WIDTH = max(CW+1, NORMREF_WIDTH)+1; PE_OUT_WIDTH = CONV_OUT_WIDTH+NORMREF_SCALE_WIDTH; CLS_W = max(clog2(FD),1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; clears pixel counter and begins a frame.
- mode  in  1  0=RAW, 1=ARGMAX; sampled at pixel accept.
- in_valid  in  1  pixel valid.
- in_ready  out  1  pixel accepted when in_valid&in_ready.
- data_in  in  D  binary pixel; bit 1 = +1, bit 0 = -1.
- cfg_we  in  1  config write strobe.
- cfg_sel  in  2  0=weight, 1=ref, 2=scale, 3=reserved (write ignored).
- cfg_addr  in  clog2(FD)  channel index.
- cfg_wdata  in  D  write data; ref and scale take the low bits.
- cfg_drop  out  1  1-cycle pulse when a cfg_we is ignored.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream ready.
- out_data  out  N_PE*PE_OUT_WIDTH  lane scores; lane 0 in the MSBs.
- out_class  out  CLS_W  argmax class index (ARGMAX mode only, else 0).
- out_last  out  1  final beat of the current pixel.
- done  out  1  1-cycle pulse after the final beat of pixel NPIX-1 is accepted.

Behaviour:
- Reset: state IDLE; in_ready=0 while rst is high and 1 in the first cycle after release. out_valid, out_data, out_class, out_last, done and cfg_drop are all 0. Pixel and group counters are 0. The weight/ref/scale arrays are not reset.
- Per-lane arithmetic, channel c = g*N_PE + lane:
  - pop = popcount(~(x ^ w_c)).
  - conv = 2*pop - D, signed, width CW+1.
  - t = conv - ref_c, sign-extended to CONV_OUT_WIDTH.
  - score = t * scale_c, signed, full PE_OUT_WIDTH; no saturation or truncation.
- FSM states: IDLE, RUN, ARG, EMIT.
- IDLE: in_ready=1. On accept, register the pixel, latch mode, set g=0, go to RUN (RAW) or ARG (ARGMAX).
- RUN (RAW mode):
  - The output register loads the group-g scores whenever !out_valid || out_ready.
  - out_last = (g == G-1); g increments on each load.
  - After the final load, go to EMIT.
  - Latency: the first out_valid appears in the 2nd cycle after the accept cycle. With out_ready held high, throughput is 1 beat per cycle.
- ARG (ARGMAX mode):
  - Evaluates one group per cycle, with no backpressure, and keeps a running best score and index.
  - Comparison is signed. Ties go to the lowest channel index, both within a group and across groups.
  - After G cycles, load the output register: out_data lane 0 = best score, other lanes 0, out_class = best index, out_last=1. Then go to EMIT.
- EMIT: hold out_valid and all outputs stable until out_ready. On the handshake: out_valid=0, pixel counter increments, return to IDLE.
- done: pulses on the handshake where the pixel counter goes NPIX-1 -> 0 (the counter wraps to 0). start in any state zeroes the pixel counter; it does not abort an in-flight pixel.
- RAW backpressure: out_data/out_last must stay stable while out_valid && !out_ready. g does not advance in that case.
- Config writes:
  - Honoured only in IDLE, and only when no pixel is accepted in that same cycle.
  - Otherwise the write is ignored and cfg_drop pulses for 1 cycle.
  - A write to cfg_sel=3 is ignored without a cfg_drop pulse.
  - A write in cycle t is visible to a pixel accepted in cycle t+1 or later.
- Reset mid-operation: returns to the reset state immediately. Any beat in flight is discarded.

Decomposition:
- Package bcedn_head_pkg:
  - state enum {IDLE, RUN, ARG, EMIT};
  - mode enum {RAW, ARGMAX};
  - cfg_sel constants;
  - width functions for CW, CONV_OUT_WIDTH and PE_OUT_WIDTH.
- Sub-module bcedn_xnor_pe: combinational single lane (x, w, ref, scale -> score). Instantiated N_PE times.
- The top level holds the FSM, the config arrays, the argmax reduction and the output register.

Test Plan:
- Configuration for all scenarios: D=8, FD=4, N_PE=2, NPIX=2, ref=0, scale=1 unless stated; weights ch0=0xFF, ch1=0x00, ch2=0x0F, ch3=0xF0.
- RAW, pixel 0xFF, out_ready=1 -> beat0 {8,-8}, beat1 {0,0} with out_last; first out_valid in the 2nd cycle after accept.
- RAW with out_ready low for 3 cycles on beat0 -> beat0 held stable, no beat lost or duplicated, 2 beats total.
- ARGMAX, pixel 0x0F -> single beat, out_class=2, lane0 score=8, lane1=0, out_last=1.
- ARGMAX tie: pixel 0x00, ch1 and ch3 weights both 0x00 -> out_class=1; then ch0 ref=2, scale=-3, pixel 0xFF -> lane0 score -18 in RAW.
- Two pixels back-to-back -> done pulses exactly once, on the 2nd pixel's last handshake; start then resets the count.
- cfg_we during RUN -> cfg_drop pulses, the weight is unchanged on the next pixel; asserting rst mid-EMIT -> out_valid=0 and in_ready=1 in the first cycle after reset releases.
